// File: rtl/switch_core_pkg.sv
// Shared definitions for the switch core.
// Contents:
//   arb_state_e       - frame arbiter FSM states (IDLE, STREAM, DRAIN)
//   FRAME_EOF_BIT     - bit position of the end-of-frame flag in a frame word
//   FRAME_WORD_WIDTH  - width of a frame word (end-of-frame flag plus one byte)
//   frame_is_eof()    - extracts the end-of-frame flag from a frame word
package switch_core_pkg;

  localparam int FRAME_EOF_BIT    = 8;
  localparam int FRAME_WORD_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  function automatic logic frame_is_eof(input logic [FRAME_WORD_WIDTH-1:0] word);
    return word[FRAME_EOF_BIT];
  endfunction

endpackage

// File: rtl/round_robin_selector.sv
// Combinational round-robin pick.
// Searches the request vector starting at last_grant_i+1 (wrapping modulo
// NUMBER_OF_PORTS) and reports the first requesting index.
// Ports:
//   request_i      in   [NUMBER_OF_PORTS]  one bit per requesting port
//   last_grant_i   in   index of the most recent grant
//   next_index_o   out  selected index (last_grant_i when nothing requests)
//   any_request_o  out  at least one request bit is set
module round_robin_selector
  import switch_core_pkg::*;
#(
  parameter int NUMBER_OF_PORTS = 4
) (
  input  logic [NUMBER_OF_PORTS-1:0]         request_i,
  input  logic [$clog2(NUMBER_OF_PORTS)-1:0] last_grant_i,
  output logic [$clog2(NUMBER_OF_PORTS)-1:0] next_index_o,
  output logic                               any_request_o
);

  localparam int IDX_W = $clog2(NUMBER_OF_PORTS);

  logic [IDX_W-1:0] candidate_s;
  logic             take_s;

  // Walk the ports in rotating priority order; the first hit wins and later
  // hits are ignored because any_request_o is already set.
  always_comb begin
    next_index_o  = last_grant_i;
    any_request_o = 1'b0;
    candidate_s   = {IDX_W{1'b0}};
    take_s        = 1'b0;
    for (int k = 1; k <= NUMBER_OF_PORTS; k++) begin
      candidate_s   = IDX_W'((int'(last_grant_i) + k) % NUMBER_OF_PORTS);
      take_s        = request_i[candidate_s] & ~any_request_o;
      next_index_o  = take_s ? candidate_s : next_index_o;
      any_request_o = any_request_o | request_i[candidate_s];
    end
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-level round-robin arbiter for the switch core forwarding path.
// One ingress port is granted at a time; its 9-bit words (bit 8 = EOF) are
// muxed combinationally onto frame_data and the grant is held until EOF.
// Oversize frames are cut with length_error and the tail is discarded;
// a stalled grant is revoked with timeout_error.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   port_receive_data_valid/_data/_ready   per-port word handshake
//   frame_ready                  downstream accepts a word
//   frame_data, frame_data_valid muxed word of the granted port
//   frame_port_index             granted port (held for the whole grant)
//   frame_start                  first word of a frame is presented
//   length_error, timeout_error  single-cycle error pulses
//   frames_forwarded             wrapping count of forwarded EOFs
module ingress_frame_arbiter
  import switch_core_pkg::*;
#(
  parameter int NUMBER_OF_PORTS = 4,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUMBER_OF_PORTS-1:0]                      port_receive_data_valid,
  input  logic [NUMBER_OF_PORTS-1:0][FRAME_WORD_WIDTH-1:0] port_receive_data,
  output logic [NUMBER_OF_PORTS-1:0]                      port_receive_data_ready,
  input  logic                                            frame_ready,
  output logic [FRAME_WORD_WIDTH-1:0]                     frame_data,
  output logic                                            frame_data_valid,
  output logic [$clog2(NUMBER_OF_PORTS)-1:0]              frame_port_index,
  output logic                                            frame_start,
  output logic                                            length_error,
  output logic                                            timeout_error,
  output logic [15:0]                                     frames_forwarded
);

  localparam int IDX_W = $clog2(NUMBER_OF_PORTS);
  localparam int BC_W  = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IC_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [BC_W-1:0]  MAX_BYTES_C  = BC_W'(MAX_FRAME_BYTES);
  localparam logic [IC_W-1:0]  IDLE_LAST_C  = IC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_PORT_C  = IDX_W'(NUMBER_OF_PORTS - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [BC_W-1:0]   byte_count_q, byte_count_d;
  logic [IC_W-1:0]   idle_count_q, idle_count_d;
  logic [15:0]       frames_q, frames_d;

  logic [IDX_W-1:0]            next_index_s;
  logic                        any_request_s;
  logic                        sel_valid_s;
  logic [FRAME_WORD_WIDTH-1:0] sel_word_s;
  logic                        sel_eof_s;
  logic                        idle_expired_s;

  round_robin_selector #(
    .NUMBER_OF_PORTS(NUMBER_OF_PORTS)
  ) u_selector (
    .request_i     (port_receive_data_valid),
    .last_grant_i  (last_grant_q),
    .next_index_o  (next_index_s),
    .any_request_o (any_request_s)
  );

  assign sel_valid_s      = port_receive_data_valid[grant_q];
  assign sel_word_s       = port_receive_data[grant_q];
  assign sel_eof_s        = frame_is_eof(sel_word_s);
  assign idle_expired_s   = (idle_count_q == IDLE_LAST_C);
  assign frame_port_index = grant_q;
  assign frames_forwarded = frames_q;

  // Next-state and handshake decode for the grant FSM.
  always_comb begin
    state_d                 = state_q;
    grant_d                 = grant_q;
    last_grant_d            = last_grant_q;
    byte_count_d            = byte_count_q;
    idle_count_d            = idle_count_q;
    frames_d                = frames_q;
    port_receive_data_ready = {NUMBER_OF_PORTS{1'b0}};
    frame_data              = {FRAME_WORD_WIDTH{1'b0}};
    frame_data_valid        = 1'b0;
    frame_start             = 1'b0;
    length_error            = 1'b0;
    timeout_error           = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_request_s) begin
          grant_d      = next_index_s;
          last_grant_d = next_index_s;
          byte_count_d = {BC_W{1'b0}};
          idle_count_d = {IC_W{1'b0}};
          state_d      = STREAM;
        end else begin
          state_d = IDLE;
        end
      end

      STREAM: begin
        port_receive_data_ready[grant_q] = frame_ready;
        frame_data       = sel_word_s;
        frame_data_valid = sel_valid_s;
        frame_start      = sel_valid_s & (byte_count_q == {BC_W{1'b0}});
        if (sel_valid_s && frame_ready) begin
          idle_count_d = {IC_W{1'b0}};
          byte_count_d = byte_count_q + BC_W'(1'b1);
          // EOF is checked first so a frame of exactly the limit is legal.
          if (sel_eof_s) begin
            frames_d = frames_q + 16'd1;
            state_d  = IDLE;
          end else if ((byte_count_q + BC_W'(1'b1)) == MAX_BYTES_C) begin
            length_error = 1'b1;
            state_d      = DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else if (idle_expired_s) begin
          // Revoke the grant; the rest of the frame stays in the port queue.
          timeout_error = 1'b1;
          state_d       = IDLE;
        end else begin
          idle_count_d = idle_count_q + IC_W'(1'b1);
        end
      end

      DRAIN: begin
        // Swallow the oversize tail without presenting it downstream.
        port_receive_data_ready[grant_q] = sel_valid_s;
        if (sel_valid_s) begin
          idle_count_d = {IC_W{1'b0}};
          state_d      = sel_eof_s ? IDLE : DRAIN;
        end else if (idle_expired_s) begin
          timeout_error = 1'b1;
          state_d       = IDLE;
        end else begin
          idle_count_d = idle_count_q + IC_W'(1'b1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= {IDX_W{1'b0}};
      last_grant_q <= LAST_PORT_C;
      byte_count_q <= {BC_W{1'b0}};
      idle_count_q <= {IC_W{1'b0}};
      frames_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_count_q <= byte_count_d;
      idle_count_q <= idle_count_d;
      frames_q     <= frames_d;
    end
  end

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
module tb_ingress_frame_arbiter;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int MAXB = 1522;
  localparam int TO   = 1024;

  logic              clock;
  logic              reset;
  logic [N-1:0]      prdv;
  logic [N-1:0][8:0] prd;
  logic [N-1:0]      prdr;
  logic              frame_ready;
  logic [8:0]        frame_data;
  logic              frame_data_valid;
  logic [IW-1:0]     frame_port_index;
  logic              frame_start;
  logic              length_error;
  logic              timeout_error;
  logic [15:0]       frames_forwarded;

  ingress_frame_arbiter #(
    .NUMBER_OF_PORTS(N),
    .MAX_FRAME_BYTES(MAXB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .port_receive_data_valid (prdv),
    .port_receive_data       (prd),
    .port_receive_data_ready (prdr),
    .frame_ready             (frame_ready),
    .frame_data              (frame_data),
    .frame_data_valid        (frame_data_valid),
    .frame_port_index        (frame_port_index),
    .frame_start             (frame_start),
    .length_error            (length_error),
    .timeout_error           (timeout_error),
    .frames_forwarded        (frames_forwarded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Traffic sources, what was sent and what came out, per port.
  logic [8:0] src_q  [N][$];
  logic [8:0] sent_q [N][$];
  logic [8:0] fwd_q  [N][$];
  logic [N-1:0] src_en;
  // Forwarded-word log in arrival order.
  int         log_port[$];
  int         log_cyc[$];
  bit         log_start[$];
  int n_cmp, n_bad, cyc;
  int n_lerr, n_terr, lerr_cyc, terr_cyc;
  // Reference model: which port holds the grant (-1 = none), discard mode,
  // bytes taken in this frame, cycles since last take, forwarded frames.
  int m_grant, m_last, m_index, m_bytes, m_idle, m_frames;
  bit m_drop;

  task automatic model_reset();
    m_grant = -1; m_last = N - 1; m_index = 0;
    m_bytes = 0; m_idle = 0; m_frames = 0; m_drop = 1'b0;
  endtask

  task automatic clear_traffic();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete(); sent_q[p].delete(); fwd_q[p].delete();
    end
    log_port.delete(); log_cyc.delete(); log_start.delete();
    n_lerr = 0; n_terr = 0; lerr_cyc = -1; terr_cyc = -1;
    src_en = {N{1'b1}};
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      prdv[IW'(p)] = src_en[IW'(p)] && (src_q[p].size() > 0);
      prd[IW'(p)]  = (src_q[p].size() > 0) ? src_q[p][0] : 9'h000;
    end
  endtask

  task automatic push_frame(input int p, input int len);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 8'($urandom)};
      src_q[p].push_back(w);
      sent_q[p].push_back(w);
    end
  endtask

  function automatic bit sources_empty();
    for (int p = 0; p < N; p++)
      if (src_en[IW'(p)] && src_q[p].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    frame_ready = 1'b1;
    clear_traffic();
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One clock: check DUT outputs against the model at the falling edge,
  // then consume accepted words and re-drive the sources after the rising edge.
  task automatic tick();
    logic [N-1:0] e_rdy, o_rdy;
    logic [8:0]   e_data, w;
    logic         e_fdv, e_fst, e_lerr, e_terr;
    logic [15:0]  e_ffw;
    logic [IW-1:0] e_idx;
    int g, p;
    bit found, v, xfer;
    @(negedge clock);
    cyc++;
    e_rdy = '0; e_data = 9'h000; e_fdv = 1'b0; e_fst = 1'b0; e_lerr = 1'b0; e_terr = 1'b0;
    e_ffw = 16'(m_frames); e_idx = IW'(m_index); xfer = 1'b0;
    if (m_grant < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (!found && prdv[IW'(p)]) begin
          found = 1'b1; m_grant = p; m_last = p; m_index = p;
          m_bytes = 0; m_idle = 0; m_drop = 1'b0;
        end
      end
    end else begin
      g = m_grant; v = prdv[IW'(g)]; w = prd[IW'(g)];
      if (m_drop) begin
        e_rdy[IW'(g)] = v; xfer = v;
      end else begin
        e_rdy[IW'(g)] = frame_ready; e_fdv = v; e_data = w;
        e_fst = v && (m_bytes == 0); xfer = v && frame_ready;
      end
      if (xfer) begin
        m_idle = 0; m_bytes++;
        if (w[8]) begin
          if (!m_drop) m_frames = (m_frames + 1) % 65536;
          m_grant = -1;
        end else if (!m_drop && m_bytes == MAXB) begin
          e_lerr = 1'b1; m_drop = 1'b1;
        end
      end else if (m_idle == TO - 1) begin
        e_terr = 1'b1; m_grant = -1;
      end else begin
        m_idle++;
      end
    end
    n_cmp++; if (prdr !== e_rdy) begin n_bad++; $display("FAIL ready cyc=%0d: got %b want %b", cyc, prdr, e_rdy); end
    n_cmp++; if (frame_data_valid !== e_fdv) begin n_bad++; $display("FAIL frame_data_valid cyc=%0d: got %b want %b", cyc, frame_data_valid, e_fdv); end
    n_cmp++; if (frame_start !== e_fst) begin n_bad++; $display("FAIL frame_start cyc=%0d: got %b want %b", cyc, frame_start, e_fst); end
    n_cmp++; if (length_error !== e_lerr) begin n_bad++; $display("FAIL length_error cyc=%0d: got %b want %b", cyc, length_error, e_lerr); end
    n_cmp++; if (timeout_error !== e_terr) begin n_bad++; $display("FAIL timeout_error cyc=%0d: got %b want %b", cyc, timeout_error, e_terr); end
    n_cmp++; if (frames_forwarded !== e_ffw) begin n_bad++; $display("FAIL frames_forwarded cyc=%0d: got %0d want %0d", cyc, frames_forwarded, e_ffw); end
    n_cmp++; if (frame_port_index !== e_idx) begin n_bad++; $display("FAIL frame_port_index cyc=%0d: got %0d want %0d", cyc, frame_port_index, e_idx); end
    if (e_fdv) begin
      n_cmp++; if (frame_data !== e_data) begin n_bad++; $display("FAIL frame_data cyc=%0d: got %h want %h", cyc, frame_data, e_data); end
    end
    o_rdy = prdr & prdv;
    if (frame_data_valid && (o_rdy != '0)) begin
      fwd_q[frame_port_index].push_back(frame_data);
      log_port.push_back(int'(frame_port_index));
      log_cyc.push_back(cyc);
      log_start.push_back(frame_start);
    end
    if (length_error)  begin n_lerr++; lerr_cyc = cyc; end
    if (timeout_error) begin n_terr++; terr_cyc = cyc; end
    @(posedge clock);
    #1;
    for (int q = 0; q < N; q++)
      if (o_rdy[IW'(q)] && src_q[q].size() > 0) void'(src_q[q].pop_front());
    drive_inputs();
  endtask

  task automatic run_until_drained(input int budget, input string name);
    int n;
    n = 0;
    while (!(sources_empty() && m_grant < 0) && n < budget) begin
      tick(); n++;
    end
    n_cmp++;
    if (n >= budget) begin n_bad++; $display("FAIL %s_budget: ran %0d cycles, required drain within %0d", name, n, budget); end
  endtask

  task automatic check_integrity(input int p, input string name);
    bit ok;
    ok = (fwd_q[p].size() == sent_q[p].size());
    for (int i = 0; ok && i < sent_q[p].size(); i++) ok = (fwd_q[p][i] === sent_q[p][i]);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_port%0d: got %0d words (or content differs) want %0d in order", name, p, fwd_q[p].size(), sent_q[p].size()); end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_ready = 1'b1;
    clear_traffic(); model_reset();
    push_frame(2, 3);
    drive_inputs();
    #1;
    n_cmp++; if (prdr !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", prdr); end
    n_cmp++; if (frame_data_valid !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_valid_start: got %b%b want 00", frame_data_valid, frame_start); end
    n_cmp++; if (frames_forwarded !== 16'd0 || frame_port_index !== 2'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frames_forwarded, frame_port_index); end
    n_cmp++; if (length_error !== 1'b0 || timeout_error !== 1'b0) begin n_bad++; $display("FAIL reset_errors: got %b%b want 00", length_error, timeout_error); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    run_until_drained(50, "reset");
  endtask

  task automatic test_single_port();
    int c0, starts;
    bit all2;
    do_reset();
    push_frame(2, 64);
    drive_inputs();
    c0 = cyc + 1;
    run_until_drained(300, "single");
    n_cmp++;
    if (log_cyc.size() != 64) begin
      n_bad++; $display("FAIL single_count: got %0d words want 64", log_cyc.size());
    end else begin
      starts = 0; all2 = 1'b1;
      foreach (log_start[i]) begin starts += log_start[i]; all2 &= (log_port[i] == 2); end
      n_cmp++; if (log_cyc[0] != c0 + 1) begin n_bad++; $display("FAIL single_latency: got cyc %0d want %0d", log_cyc[0], c0 + 1); end
      n_cmp++; if (log_cyc[63] != c0 + 64) begin n_bad++; $display("FAIL single_last: got cyc %0d want %0d", log_cyc[63], c0 + 64); end
      n_cmp++; if (starts != 1 || !log_start[0]) begin n_bad++; $display("FAIL single_start: got %0d starts want 1 on byte 0", starts); end
      n_cmp++; if (!all2) begin n_bad++; $display("FAIL single_index: got a port other than 2 want 2"); end
    end
    n_cmp++; if (frames_forwarded !== 16'd1) begin n_bad++; $display("FAIL single_frames: got %0d want 1", frames_forwarded); end
    check_integrity(2, "single");
  endtask

  task automatic test_fairness();
    int sp[$]; int sc[$]; int ec[$];
    do_reset();
    for (int f = 0; f < 3; f++) for (int p = 0; p < N; p++) push_frame(p, 4);
    drive_inputs();
    run_until_drained(200, "fair");
    foreach (log_cyc[i]) begin
      if (log_start[i]) begin sp.push_back(log_port[i]); sc.push_back(log_cyc[i]); end
      if (i % 4 == 3) ec.push_back(log_cyc[i]);
    end
    n_cmp++;
    if (sp.size() != 12 || ec.size() != 12) begin
      n_bad++; $display("FAIL fair_frames: got %0d starts want 12", sp.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++; if (sp[i] != i % N) begin n_bad++; $display("FAIL fair_order[%0d]: got port %0d want %0d", i, sp[i], i % N); end
        if (i > 0) begin
          n_cmp++; if (sc[i] - ec[i-1] != 2) begin n_bad++; $display("FAIL fair_gap[%0d]: got %0d want 2", i, sc[i] - ec[i-1]); end
        end
      end
    end
    n_cmp++; if (frames_forwarded !== 16'd12) begin n_bad++; $display("FAIL fair_count: got %0d want 12", frames_forwarded); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    push_frame(1, $urandom_range(20, 40));
    push_frame(3, $urandom_range(20, 40));
    push_frame(1, $urandom_range(20, 40));
    drive_inputs();
    n = 0;
    while (!(sources_empty() && m_grant < 0) && n < 800) begin
      frame_ready = ~frame_ready; tick(); n++;
    end
    n_cmp++; if (n >= 800) begin n_bad++; $display("FAIL bp_budget: ran %0d cycles want under 800", n); end
    check_integrity(1, "bp");
    check_integrity(3, "bp");
    n_cmp++; if (frames_forwarded !== 16'd3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", frames_forwarded); end
  endtask

  task automatic test_random_mix();
    int n;
    do_reset();
    for (int f = 0; f < 10; f++) push_frame($urandom_range(0, N - 1), $urandom_range(1, 24));
    drive_inputs();
    n = 0;
    while (!(sources_empty() && m_grant < 0) && n < 3000) begin
      for (int p = 0; p < N; p++) src_en[IW'(p)] = ($urandom_range(0, 3) != 0);
      frame_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
      tick(); n++;
      src_en = {N{1'b1}};
    end
    n_cmp++; if (n >= 3000) begin n_bad++; $display("FAIL rand_budget: ran %0d cycles want under 3000", n); end
    for (int p = 0; p < N; p++) check_integrity(p, "rand");
    n_cmp++; if (frames_forwarded !== 16'd10) begin n_bad++; $display("FAIL rand_count: got %0d want 10", frames_forwarded); end
  endtask

  task automatic test_oversize();
    bit ok;
    do_reset();
    push_frame(1, MAXB);
    push_frame(1, 1600);
    drive_inputs();
    run_until_drained(4000, "over");
    n_cmp++; if (n_lerr != 1) begin n_bad++; $display("FAIL over_pulses: got %0d want 1", n_lerr); end
    n_cmp++;
    if (fwd_q[1].size() != 2 * MAXB) begin
      n_bad++; $display("FAIL over_fwd: got %0d words want %0d", fwd_q[1].size(), 2 * MAXB);
    end else begin
      ok = 1'b1;
      for (int i = 0; i < 2 * MAXB; i++) ok &= (fwd_q[1][i] === sent_q[1][i]);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL over_data: got altered words want source order"); end
      n_cmp++; if (lerr_cyc != log_cyc[2 * MAXB - 1]) begin n_bad++; $display("FAIL over_when: got cyc %0d want %0d", lerr_cyc, log_cyc[2 * MAXB - 1]); end
    end
    n_cmp++; if (src_q[1].size() != 0) begin n_bad++; $display("FAIL over_drain: got %0d left want 0", src_q[1].size()); end
    n_cmp++; if (frames_forwarded !== 16'd1) begin n_bad++; $display("FAIL over_count: got %0d want 1", frames_forwarded); end
  endtask

  task automatic test_stall();
    int n, nxt;
    do_reset();
    push_frame(0, 20);
    push_frame(3, 4);
    drive_inputs();
    n = 0;
    while (terr_cyc < 0 && n < 1200) begin
      tick(); n++;
      if (src_en[0] && fwd_q[0].size() == 10) begin src_en[0] = 1'b0; drive_inputs(); end
    end
    n_cmp++;
    if (terr_cyc < 0 || log_cyc.size() < 10) begin
      n_bad++; $display("FAIL stall_seen: got no timeout within %0d cycles want one", n);
    end else begin
      n_cmp++; if (terr_cyc - log_cyc[9] != TO) begin n_bad++; $display("FAIL stall_delay: got %0d want %0d", terr_cyc - log_cyc[9], TO); end
    end
    run_until_drained(100, "stall");
    nxt = -1;
    foreach (log_cyc[i]) if (nxt < 0 && log_start[i] && log_cyc[i] > terr_cyc) nxt = i;
    n_cmp++;
    if (nxt < 0) begin
      n_bad++; $display("FAIL stall_next: got no frame after timeout want port 3");
    end else if (log_port[nxt] != 3 || log_cyc[nxt] != terr_cyc + 2) begin
      n_bad++; $display("FAIL stall_next: got port %0d at +%0d want port 3 at +2", log_port[nxt], log_cyc[nxt] - terr_cyc);
    end
    n_cmp++; if (n_terr != 1 || src_q[0].size() != 10) begin n_bad++; $display("FAIL stall_left: got %0d pulses/%0d queued want 1/10", n_terr, src_q[0].size()); end
  endtask

  task automatic test_reset_mid_frame();
    int first;
    do_reset();
    push_frame(1, 30);
    drive_inputs();
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (prdr !== 4'b0000 || frame_data_valid !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL midrst_hs: got rdy=%b v=%b s=%b want 0", prdr, frame_data_valid, frame_start); end
    n_cmp++; if (frame_data !== 9'h000 || frame_port_index !== 2'd0) begin n_bad++; $display("FAIL midrst_data: got %h/%0d want 000/0", frame_data, frame_port_index); end
    n_cmp++; if (frames_forwarded !== 16'd0 || length_error !== 1'b0 || timeout_error !== 1'b0) begin n_bad++; $display("FAIL midrst_misc: got %0d/%b/%b want 0", frames_forwarded, length_error, timeout_error); end
    clear_traffic();
    model_reset();
    push_frame(1, 5);
    push_frame(0, 5);
    drive_inputs();
    @(posedge clock);
    #1 reset = 1'b0;
    run_until_drained(100, "midrst");
    first = (log_port.size() > 0) ? log_port[0] : -1;
    n_cmp++; if (first != 0) begin n_bad++; $display("FAIL midrst_first: got port %0d want 0", first); end
    n_cmp++; if (frames_forwarded !== 16'd2) begin n_bad++; $display("FAIL midrst_count: got %0d want 2", frames_forwarded); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; frame_ready = 1'b1;
    prdv = '0; prd = '0; src_en = '1;
    test_reset();
    test_single_port();
    test_fairness();
    test_backpressure();
    test_random_mix();
    test_oversize();
    test_stall();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ingress_frame_arbiter.md
# ingress_frame_arbiter

Frame-level round-robin arbiter that shares the switch core's single forwarding path among all ingress ports (RMII and virtual). It grants one port at a time, passes that port's 9-bit byte stream to the forwarding logic with zero latency, and holds the grant until end-of-frame. It enforces maximum frame length and a stall timeout, and counts forwarded frames. It sits between the per-port receive queues and the core data orchestrator.

## Interface
Parameters:
- NUMBER_OF_PORTS, 4: ingress ports arbitrated (≥2).
- MAX_FRAME_BYTES, 1522: longest legal frame, EOF byte included.
- TIMEOUT_CYCLES, 1024: consecutive idle cycles in STREAM before the grant is revoked.

Ports (word format: bit 8 = end-of-frame, bits 7:0 = byte):
- clock  in  1  sole clock; every register uses the rising edge.
- reset  in  1  asynchronous, active-high.
- port_receive_data_valid  in  [NUMBER_OF_PORTS]  port has a word available.
- port_receive_data  in  [NUMBER_OF_PORTS][8:0]  per-port word.
- port_receive_data_ready  out  [NUMBER_OF_PORTS]  word consumed this cycle; one-hot or zero.
- frame_ready  in  1  downstream accepts a word.
- frame_data  out  9  muxed word of the granted port.
- frame_data_valid  out  1  frame_data is valid.
- frame_port_index  out  $clog2(NUMBER_OF_PORTS)  granted port.
- frame_start  out  1  first word of a frame is on frame_data.
- length_error  out  1  one-cycle pulse on oversize frame.
- timeout_error  out  1  one-cycle pulse on stall revoke.
- frames_forwarded  out  16  count of EOFs forwarded; wraps.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: no ready, no valid. If any valid bit is set, select the first requester searching from last_grant+1 modulo NUMBER_OF_PORTS. Register it into grant and last_grant, clear byte_count and idle_count, and go to STREAM. With no requester, stay in IDLE.
- STREAM:
  - port_receive_data_ready[grant] = frame_ready.
  - frame_data = port_receive_data[grant].
  - frame_data_valid = port_receive_data_valid[grant].
  - A transfer occurs when valid[grant] & frame_ready.
  - frame_start is high for the first transfer of the frame only.
- Transfer with bit 8 set: increment frames_forwarded and go to IDLE.
- Transfer without EOF where byte_count+1 == MAX_FRAME_BYTES: pulse length_error and go to DRAIN.
- idle_count counts cycles with no transfer and resets to 0 on each transfer. When it reaches TIMEOUT_CYCLES-1 with no transfer, pulse timeout_error and go to IDLE. The remainder of the frame is left in the port queue.
- DRAIN: port_receive_data_ready[grant] = port_receive_data_valid[grant], frame_data_valid = 0, and words are discarded. An EOF transfer returns the block to IDLE. The idle timeout still applies; expiry pulses timeout_error and returns to IDLE.
- Outputs outside STREAM/DRAIN: all ready bits, frame_data_valid and frame_start are 0.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=NUMBER_OF_PORTS-1 (port 0 wins first), byte_count=0, idle_count=0.
  - All outputs are 0, frames_forwarded=0.
- Data path latency is 0 cycles: combinational mux from the granted port.
- Grant latency: request seen in IDLE at cycle n; first transfer possible at n+1.
- At least one IDLE cycle follows every EOF, timeout or drain completion. Back-to-back frames therefore cost one dead cycle.
- An EOF transfer on the same cycle the length limit is reached is a legal frame: no error, go to IDLE.
- EOF and timeout expiry never coincide, because a transfer clears idle_count.
- Valid bits of non-granted ports are ignored during STREAM/DRAIN.
- frame_port_index is stable for the whole grant.
- Reset asserted mid-frame returns the block to IDLE immediately. The partial frame is not completed.
- Widths:
  - byte_count: $clog2(MAX_FRAME_BYTES+1).
  - idle_count: $clog2(TIMEOUT_CYCLES).
  - frames_forwarded: wraps 0xFFFF→0x0000.

## Structure
- Shared package switch_core_pkg holds:
  - the arbiter state enum (IDLE, STREAM, DRAIN);
  - FRAME_EOF_BIT=8 and FRAME_WORD_WIDTH=9.
- Sub-module round_robin_selector(NUMBER_OF_PORTS): inputs request vector and last_grant, outputs next index and an any_request flag; purely combinational.
- This block holds all counters and the FSM.

## Test plan
- Single port: port 2 sends a 64-byte frame with frame_ready=1. Required: first transfer 1 cycle after valid, frame_start on byte 0 only, frame_port_index=2, frames_forwarded=1, return to IDLE.
- Fairness: all four ports continuously request 4-byte frames. Required grant order 0,1,2,3,0 with one IDLE cycle between frames.
- Backpressure: toggle frame_ready every other cycle mid-frame. Required: ready is low whenever frame_ready is low, no word is lost or duplicated, and the sequence is intact.
- Oversize: 1600-byte frame with MAX_FRAME_BYTES=1522. Required: length_error pulse on byte 1522, frame_data_valid=0 thereafter, the remaining 78 bytes are drained, then IDLE.
- Stall: the granted port drops valid after 10 bytes. Required: timeout_error exactly TIMEOUT_CYCLES cycles after the last transfer, then IDLE, and the next requester is granted.
- Reset mid-frame during STREAM on port 1. Required: all outputs 0 immediately and port 0 wins the first arbitration after reset.
